seq_mult_signed: RTL and testbench

Parametrised sequential signed (two's-complement) multiplier that computes a 2·WIDTH-bit product by shift-and-add, one multiplier bit per clock. It generalises the lab 5 fixed-width datapath: the WIDTH+1-bit sign-extending add/subtract stage is sized from the WIDTH parameter, and the block adds its own control FSM, bit counter and start/done handshake. It sits between the operand switch/register front end and the hex-display/result logic.

---
 rtl/seq_mult_signed.sv | 138 +++++++++++++
 tb/tb_seq_mult_signed.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed.sv
// Sequential two's-complement shift-and-add multiplier: one multiplier bit per clock, 2*WIDTH-bit product.
// Optional overflow flag output o_ovf is built only when SEQ_MULT_OVF_EN is defined.
module seq_mult_signed #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_x,
`ifdef SEQ_MULT_OVF_EN
  output logic               o_ovf,
`endif
  output logic [1:0]         o_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_x;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_xa;
  logic [WIDTH-1:0]   w_a_next;
  logic [WIDTH-1:0]   w_b_next;
  logic               w_x_next;
  logic [2*WIDTH-1:0] w_prod_next;

  // Handshake: i_start is a request seen only in IDLE (accepted on that edge);
  // requests while busy are dropped. o_done is a one-cycle completion pulse and
  // o_product stays stable from that cycle until the next completion or reset.
  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_CALC;
      ST_CALC: if (w_last)  w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The MSB of the multiplier carries negative weight, so the final step subtracts.
  always_comb begin
    w_addend    = {r_s[WIDTH-1], r_s} ^ {(WIDTH+1){w_last}};
    w_sum       = {r_a[WIDTH-1], r_a} + w_addend + (WIDTH+1)'(w_last);
    w_xa        = r_b[0] ? w_sum : {r_a[WIDTH-1], r_a};
    w_x_next    = w_xa[WIDTH];
    w_a_next    = w_xa[WIDTH:1];
    w_b_next    = {w_xa[0], r_b[WIDTH-1:1]};
    w_prod_next = {w_a_next, w_b_next};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_x       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_s   <= i_mcand;
      r_b   <= i_mplier;
      r_a   <= '0;
      r_x   <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == ST_CALC) begin
      r_a   <= w_a_next;
      r_b   <= w_b_next;
      r_x   <= w_x_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_product <= w_prod_next;
      end
    end
  end

`ifdef SEQ_MULT_OVF_EN
  logic r_ovf;
  logic w_ovf_next;
  logic [WIDTH:0] w_upper;

  // Representable as WIDTH-bit signed only if the top WIDTH+1 bits are a pure sign extension.
  always_comb begin
    w_upper    = w_prod_next[2*WIDTH-1:WIDTH-1];
    w_ovf_next = !((&w_upper) || !(|w_upper));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_CALC) && w_last) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign o_ovf = r_ovf;
`endif

  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_DONE);
  assign o_product = r_product;
  assign o_x       = r_x;
  assign o_state   = r_state;

endmodule

// File: tb/tb_seq_mult_signed.sv
// Directed bench for seq_mult_signed (WIDTH=8 and WIDTH=16 instances) with a scoreboard
// queue per instance; builds with or without SEQ_MULT_OVF_EN.
module tb_seq_mult_signed;
  localparam int W  = 8;
  localparam int WW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start;
  logic [W-1:0]    mcand, mplier;
  logic            busy, done, x;
  logic [2*W-1:0]  product;
  logic [1:0]      state;
  logic            ovf;

  logic            start_w;
  logic [WW-1:0]   mcand_w, mplier_w;
  logic            busy_w, done_w, x_w;
  logic [2*WW-1:0] product_w;
  logic [1:0]      state_w;
  logic            ovf_w;

  seq_mult_signed #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mcand(mcand), .i_mplier(mplier),
    .o_busy(busy), .o_done(done), .o_product(product), .o_x(x),
`ifdef SEQ_MULT_OVF_EN
    .o_ovf(ovf),
`endif
    .o_state(state)
  );

  seq_mult_signed #(.WIDTH(WW)) dut_w (
    .i_clk(clk), .i_reset(rst), .i_start(start_w), .i_mcand(mcand_w), .i_mplier(mplier_w),
    .o_busy(busy_w), .o_done(done_w), .o_product(product_w), .o_x(x_w),
`ifdef SEQ_MULT_OVF_EN
    .o_ovf(ovf_w),
`endif
    .o_state(state_w)
  );

`ifndef SEQ_MULT_OVF_EN
  assign ovf   = 1'b0;
  assign ovf_w = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W:0]  exp_q[$];
  logic [2*WW:0] exp_w_q[$];
  logic [2*W:0]  e8;
  logic [2*WW:0] e16;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop one expectation per Done pulse.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done8: got done=1 expected no pulse at %0t", $time);
      end else begin
        e8 = exp_q.pop_front();
        check("product8", 64'(product), 64'(e8[2*W-1:0]));
        check("x8", 64'(x), 64'(e8[2*W-1]));
`ifdef SEQ_MULT_OVF_EN
        check("ovf8", 64'(ovf), 64'(e8[2*W]));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done_w === 1'b1) begin
      if (exp_w_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done16: got done=1 expected no pulse at %0t", $time);
      end else begin
        e16 = exp_w_q.pop_front();
        check("product16", 64'(product_w), 64'(e16[2*WW-1:0]));
`ifdef SEQ_MULT_OVF_EN
        check("ovf16", 64'(ovf_w), 64'(e16[2*WW]));
`endif
      end
    end
  end

  task automatic wait_idle8();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_timeout8", 64'(busy), 64'd0);
  endtask

  // One multiply on the WIDTH=8 instance; optionally pulses Start mid-CALC with other operands.
  task automatic mult8(input logic [W-1:0] mc, input logic [W-1:0] mp,
                       input logic [2*W-1:0] p, input logic ov, input bit glitch);
    int n, nb;
    wait_idle8();
    @(negedge clk);
    mcand = mc; mplier = mp; start = 1'b1;
    exp_q.push_back({ov, p});
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start  = 1'b0;
        mcand  = W'($urandom_range(0, 255));
        mplier = W'($urandom_range(0, 255));
      end
      if (glitch && n == 3) begin start = 1'b1; mcand = 8'd100; mplier = 8'd100; end
      if (glitch && n == 4) start = 1'b0;
      if (busy === 1'b1) nb++;
    end while (done !== 1'b1 && n < 40);
    check("done_latency8", 64'(n), 64'(W + 1));
    check("busy_cycles8", 64'(nb), 64'(W + 1));
    @(negedge clk);
    check("busy_fall8", 64'(busy), 64'd0);
    check("done_pulse8", 64'(done), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, t2;
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    start_w = 1'b0; mcand_w = '0; mplier_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_x", 64'(x), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_product16", 64'(product_w), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    mult8(8'd7,   8'hFD, 16'hFFEB, 1'b0, 1'b0);
    mult8(8'h80,  8'h80, 16'h4000, 1'b1, 1'b0);
    mult8(8'hFF,  8'h80, 16'h0080, 1'b1, 1'b0);
    mult8(8'd1,   8'h80, 16'hFF80, 1'b0, 1'b0);
    mult8(8'd0,   8'hFB, 16'h0000, 1'b0, 1'b0);
    mult8(8'h80,  8'd127, 16'hC080, 1'b1, 1'b1);
    repeat (15) @(negedge clk);

    // Back-to-back with Start held high.
    wait_idle8();
    @(negedge clk);
    mcand = 8'd127; mplier = 8'd127; start = 1'b1;
    exp_q.push_back({1'b1, 16'h3F01});
    exp_q.push_back({1'b0, 16'h0001});
    n = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) begin mcand = 8'hFF; mplier = 8'hFF; end
      if (n == 11) start = 1'b0;
      if (done === 1'b1) begin
        if (t1 == 0) t1 = n; else t2 = n;
      end
    end
    check("held_first_done", 64'(t1), 64'd9);
    check("held_spacing", 64'(t2 - t1), 64'(W + 2));

    // Reset in the 4th CALC cycle aborts the multiply.
    wait_idle8();
    @(negedge clk);
    mcand = 8'd100; mplier = 8'h9C; start = 1'b1;
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    mult8(8'd5, 8'd6, 16'h001E, 1'b0, 1'b0);

    // WIDTH=16 edge case.
    @(negedge clk);
    mcand_w = 16'h8000; mplier_w = 16'd2; start_w = 1'b1;
    exp_w_q.push_back({1'b1, 32'hFFFF0000});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start_w = 1'b0;
    end while (done_w !== 1'b1 && n < 60);
    check("done_latency16", 64'(n), 64'(WW + 1));

    repeat (12) @(negedge clk);
    check("queue_empty8", 64'(exp_q.size()), 64'd0);
    check("queue_empty16", 64'(exp_w_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
